// File: rtl/axil_ram_slave.sv
// AXI4-Lite responder in front of a word-addressed 32-bit RAM window.
// The write and read channels have independent FSMs; out-of-window accesses answer SLVERR.
module axil_ram_slave #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,

    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp
);

    localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
    localparam int unsigned TagLsb = ADDR_WIDTH + 2;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    function automatic logic in_window(input logic [31:0] addr);
        return addr[31:TagLsb] == BASE_ADDR[31:TagLsb];
    endfunction

    logic [31:0] mem [Depth];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic {WIdle, WResp} w_state_e;

    w_state_e        w_state_q;
    logic            aw_done_q, w_done_q;
    logic [31:0]     awaddr_q, wdata_q;
    logic [3:0]      wstrb_q;
    logic            awready_q, wready_q, bvalid_q;
    logic [1:0]      bresp_q;

    logic            aw_hs, w_hs, have_aw, have_w;
    logic            w_commit, wr_in_win, mem_we;
    logic [31:0]     wr_addr, wr_data;
    logic [3:0]      wr_strb;
    logic [ADDR_WIDTH-1:0] wr_idx;

    // Latched AW/W take priority over the live bus once captured.
    always_comb begin
        aw_hs     = s_axi_awvalid & awready_q;
        w_hs      = s_axi_wvalid & wready_q;
        have_aw   = aw_done_q | aw_hs;
        have_w    = w_done_q | w_hs;
        wr_addr   = aw_done_q ? awaddr_q : s_axi_awaddr;
        wr_data   = w_done_q ? wdata_q : s_axi_wdata;
        wr_strb   = w_done_q ? wstrb_q : s_axi_wstrb;
        wr_idx    = wr_addr[ADDR_WIDTH+1:2];
        wr_in_win = in_window(wr_addr);
        w_commit  = !reset && (w_state_q == WIdle) && have_aw && have_w;
        mem_we    = w_commit && wr_in_win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= WIdle;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
        end else begin
            unique case (w_state_q)
                WIdle: begin
                    if (w_commit) begin
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_in_win ? RespOkay : RespSlvErr;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        w_state_q <= WResp;
                    end else begin
                        if (aw_hs) begin
                            aw_done_q <= 1'b1;
                            awaddr_q  <= s_axi_awaddr;
                        end
                        if (w_hs) begin
                            w_done_q <= 1'b1;
                            wdata_q  <= s_axi_wdata;
                            wstrb_q  <= s_axi_wstrb;
                        end
                        awready_q <= !have_aw;
                        wready_q  <= !have_w;
                    end
                end
                WResp: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= WIdle;
                    end
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RIdle, RAccess, RResp} r_state_e;

    r_state_e    r_state_q;
    logic [31:0] araddr_q;
    logic        arready_q, rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [ADDR_WIDTH-1:0] rd_idx;

    assign rd_idx = araddr_q[ADDR_WIDTH+1:2];

    // The RAM write above is non-blocking, so a same-edge collision returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= RIdle;
            araddr_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
        end else begin
            unique case (r_state_q)
                RIdle: begin
                    if (s_axi_arvalid && arready_q) begin
                        araddr_q  <= s_axi_araddr;
                        arready_q <= 1'b0;
                        r_state_q <= RAccess;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RAccess: begin
                    rvalid_q <= 1'b1;
                    if (in_window(araddr_q)) begin
                        rdata_q <= mem[rd_idx];
                        rresp_q <= RespOkay;
                    end else begin
                        rdata_q <= '0;
                        rresp_q <= RespSlvErr;
                    end
                    r_state_q <= RResp;
                end
                RResp: begin
                    if (s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= RIdle;
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], araddr_q[1:0]};

endmodule

// File: tb/tb_axil_ram_slave.sv
// Randomised bench for axil_ram_slave; a byte-level array model predicts every response.
module tb_axil_ram_slave;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_axi_awvalid = 1'b0, s_axi_awready;
    logic [31:0] s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_wvalid = 1'b0, s_axi_wready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_bvalid, s_axi_bready = 1'b0;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid = 1'b0, s_axi_arready;
    logic [31:0] s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_rvalid, s_axi_rready = 1'b0;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;

    axil_ram_slave #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .INIT_FILE ("")
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awprot (s_axi_awprot),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arprot (s_axi_arprot),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] ref_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_in_win(input logic [31:0] addr);
        return (addr / (4 * DEPTH)) == (BASE / (4 * DEPTH));
    endfunction

    function automatic int ref_idx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    function automatic void ref_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
        if (!ref_in_win(addr)) return;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) ref_mem[ref_idx(addr)][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        int c = 0;
        logic [1:0] exp_resp;
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        while (!(aw_done && w_done) && c < 100) begin
            @(negedge clk);
            s_axi_awvalid = !aw_done && c >= aw_dly;
            s_axi_wvalid  = !w_done && c >= w_dly;
            if (w_done && !aw_done) check("wready_hold", 32'(s_axi_wready), 0);
            if (aw_done && !w_done) check("awready_hold", 32'(s_axi_awready), 0);
            if (s_axi_awvalid && s_axi_awready) aw_done = 1;
            if (s_axi_wvalid && s_axi_wready) w_done = 1;
            c++;
        end
        if (!(aw_done && w_done)) begin
            check("aw_w_timeout", 32'({aw_done, w_done}), 3);
            s_axi_awvalid = 0;
            s_axi_wvalid  = 0;
            return;
        end
        @(negedge clk);
        s_axi_awvalid = 0;
        s_axi_wvalid  = 0;
        exp_resp = ref_in_win(addr) ? 2'b00 : 2'b10;
        ref_write(addr, data, strb);
        check("bvalid_lat", 32'(s_axi_bvalid), 1);
        check("bresp", 32'(s_axi_bresp), 32'(exp_resp));
        for (int i = 0; i < b_dly; i++) begin
            check("awready_busy", 32'(s_axi_awready), 0);
            check("wready_busy", 32'(s_axi_wready), 0);
            @(negedge clk);
            check("bvalid_hold", 32'(s_axi_bvalid), 1);
            check("bresp_hold", 32'(s_axi_bresp), 32'(exp_resp));
        end
        s_axi_bready = 1;
        @(negedge clk);
        s_axi_bready = 0;
        check("bvalid_clr", 32'(s_axi_bvalid), 0);
        check("awready_back", 32'(s_axi_awready), 1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
        int c = 0;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        repeat (ar_dly) @(negedge clk);
        s_axi_araddr = addr;
        do begin
            @(negedge clk);
            s_axi_arvalid = 1;
            c++;
        end while (!s_axi_arready && c < 100);
        if (!s_axi_arready) begin
            check("ar_timeout", 32'(s_axi_arready), 1);
            s_axi_arvalid = 0;
            return;
        end
        @(negedge clk);
        s_axi_arvalid = 0;
        check("rvalid_early", 32'(s_axi_rvalid), 0);
        check("arready_busy", 32'(s_axi_arready), 0);
        @(negedge clk);
        exp_data = ref_in_win(addr) ? ref_mem[ref_idx(addr)] : 32'h0;
        exp_resp = ref_in_win(addr) ? 2'b00 : 2'b10;
        check("rvalid_lat", 32'(s_axi_rvalid), 1);
        check("rdata", s_axi_rdata, exp_data);
        check("rresp", 32'(s_axi_rresp), 32'(exp_resp));
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check("rvalid_hold", 32'(s_axi_rvalid), 1);
            check("rdata_hold", s_axi_rdata, exp_data);
            check("rresp_hold", 32'(s_axi_rresp), 32'(exp_resp));
            check("arready_wait", 32'(s_axi_arready), 0);
        end
        s_axi_rready = 1;
        @(negedge clk);
        s_axi_rready = 0;
        check("rvalid_clr", 32'(s_axi_rvalid), 0);
        check("arready_back", 32'(s_axi_arready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;

        // Reset: everything quiet while asserted, readies up after release.
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(s_axi_awready), 0);
        check("rst_wready", 32'(s_axi_wready), 0);
        check("rst_arready", 32'(s_axi_arready), 0);
        check("rst_bvalid", 32'(s_axi_bvalid), 0);
        check("rst_rvalid", 32'(s_axi_rvalid), 0);
        check("rst_bresp", 32'(s_axi_bresp), 0);
        check("rst_rresp", 32'(s_axi_rresp), 0);
        check("rst_rdata", s_axi_rdata, 0);
        reset = 0;
        @(negedge clk);
        check("rel_awready", 32'(s_axi_awready), 1);
        check("rel_wready", 32'(s_axi_wready), 1);
        check("rel_arready", 32'(s_axi_arready), 1);

        // Give every word a known value so all later reads are predictable.
        for (int i = 0; i < DEPTH; i++) axi_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);

        // Aligned write/read, AW and W together.
        axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        axi_read(BASE + 32'h10, 0, 0);

        // W well ahead of AW, partial strobes over all-ones.
        axi_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(BASE + 32'h20, 32'h1122_3344, 4'b0101, 3, 0, 0);
        axi_read(BASE + 32'h20, 0, 0);
        // AW ahead of W, and an empty strobe.
        axi_write(BASE + 32'h24, 32'hCAFE_F00D, 4'hF, 0, 2, 0);
        axi_write(BASE + 32'h24, 32'h0, 4'h0, 0, 0, 0);
        axi_read(BASE + 32'h24, 0, 0);

        // Just past the window: SLVERR, must not alias onto word 0.
        axi_write(BASE + 32'(4 * DEPTH), 32'h5555_AAAA, 4'hF, 0, 0, 0);
        axi_read(BASE + 32'(4 * DEPTH), 0, 0);
        axi_read(BASE, 0, 0);
        axi_read(BASE - 4, 0, 0);

        // Master back-pressure on both response channels.
        axi_write(BASE + 32'h8, 32'h0BAD_F00D, 4'hF, 0, 0, 5);
        axi_read(BASE + 32'h8, 0, 5);

        // Write commit and read access on the same edge, same word.
        axi_write(BASE + 32'hC, 32'hA, 4'hF, 0, 0, 0);
        @(negedge clk);
        s_axi_araddr  = BASE + 32'hC;
        s_axi_arvalid = 1;
        check("col_arready", 32'(s_axi_arready), 1);
        @(negedge clk);
        s_axi_arvalid = 0;
        s_axi_awaddr  = BASE + 32'hC;
        s_axi_wdata   = 32'hB;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1;
        s_axi_wvalid  = 1;
        check("col_awready", 32'(s_axi_awready), 1);
        @(negedge clk);
        s_axi_awvalid = 0;
        s_axi_wvalid  = 0;
        check("col_rvalid", 32'(s_axi_rvalid), 1);
        check("col_rdata_old", s_axi_rdata, 32'hA);
        check("col_bvalid", 32'(s_axi_bvalid), 1);
        ref_write(BASE + 32'hC, 32'hB, 4'hF);
        s_axi_bready = 1;
        s_axi_rready = 1;
        @(negedge clk);
        s_axi_bready = 0;
        s_axi_rready = 0;
        axi_read(BASE + 32'hC, 0, 0);

        // Reset while a B response is pending and a read is in its access cycle.
        s_axi_awaddr  = BASE + 32'h14;
        s_axi_wdata   = 32'h7777_1234;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1;
        s_axi_wvalid  = 1;
        @(negedge clk);
        s_axi_awvalid = 0;
        s_axi_wvalid  = 0;
        ref_write(BASE + 32'h14, 32'h7777_1234, 4'hF);
        check("rs_bvalid_pre", 32'(s_axi_bvalid), 1);
        s_axi_araddr  = BASE + 32'h14;
        s_axi_arvalid = 1;
        @(negedge clk);
        s_axi_arvalid = 0;
        reset = 1;
        @(negedge clk);
        check("rs_bvalid_in", 32'(s_axi_bvalid), 0);
        check("rs_rvalid_in", 32'(s_axi_rvalid), 0);
        check("rs_arready_in", 32'(s_axi_arready), 0);
        reset = 0;
        @(negedge clk);
        check("rs_bvalid", 32'(s_axi_bvalid), 0);
        check("rs_rvalid", 32'(s_axi_rvalid), 0);
        check("rs_awready", 32'(s_axi_awready), 1);
        check("rs_wready", 32'(s_axi_wready), 1);
        check("rs_arready", 32'(s_axi_arready), 1);
        axi_read(BASE + 32'h14, 0, 0);

        // Random mix of reads and writes, mostly in window.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            else a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                axi_write(a, d, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
